// File: rtl/hdlc_pkg.sv
// Shared HDLC transmit types and line constants.
package hdlc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_FLAG,
    ST_DATA,
    ST_END_FLAG,
    ST_ABORT
  } tx_state_t;

  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam logic [7:0]  ABORT_PAT   = 8'hFE;
  localparam int unsigned STUFF_LIMIT = 5;
  localparam int unsigned ONES_W      = 3;

endpackage

// File: rtl/hdlc_tx_bitstuff.sv
// Zero-insertion for HDLC payload: counts consecutive 1s and forces a 0 after the limit.
module hdlc_tx_bitstuff
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  input  logic bit_in,
  output logic line_bit_c,
  output logic stall_c
);

  logic [ONES_W-1:0] ones_q, ones_d;

  // Insert a 0 (and hold the payload shifter) once the run of 1s hits the limit.
  always_comb begin
    stall_c    = (ones_q == ONES_W'(STUFF_LIMIT));
    line_bit_c = stall_c ? 1'b0 : bit_in;
  end

  // Run-length of payload 1s; any 0 on the line (real or inserted) restarts it.
  always_comb begin
    ones_d = ones_q;
    if (clear) begin
      ones_d = '0;
    end else if (advance) begin
      if (stall_c || !bit_in) ones_d = '0;
      else                    ones_d = ones_q + ONES_W'(1);
    end
  end

  // Ones-counter register.
  always_ff @(posedge clk) begin
    if (rst) ones_q <= '0;
    else     ones_q <= ones_d;
  end

endmodule

// File: rtl/hdlc_tx_channel.sv
// HDLC serial transmitter: flag, zero-inserted LSB-first payload, flag; abort on request.
module hdlc_tx_channel
  import hdlc_pkg::*;
#(
  parameter int unsigned MAX_FRAME_BYTES = 128
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tx_Enable,
  input  logic       Tx_AbortFrame,
  input  logic       Tx_DataAvail,
  input  logic [7:0] Tx_Data,
  output logic       Tx_RdBuff,
  output logic       Tx,
  output logic       Tx_ValidFrame,
  output logic       Tx_Done,
  output logic       Tx_AbortedTrans,
  output logic       Tx_Overflow
);

  localparam int unsigned BCNT_W = $clog2(MAX_FRAME_BYTES + 1);
  localparam int unsigned REM_W  = 4;

  tx_state_t         state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [BCNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic              tx_q, tx_d;
  logic              rd_buff_q, rd_buff_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              overflow_q, overflow_d;

  logic start_c, abort_c, flag_last_c, payload_c, data_end_c, room_c;
  logic stuff_clr_c, stuff_adv_c, stuff_bit_c, line_bit_c, stall_c;

  hdlc_tx_bitstuff u_bitstuff (
    .clk        (Clk),
    .rst        (Rst),
    .clear      (stuff_clr_c),
    .advance    (stuff_adv_c),
    .bit_in     (stuff_bit_c),
    .line_bit_c (line_bit_c),
    .stall_c    (stall_c)
  );

  // Decoded conditions shared by the next-state and output logic.
  always_comb begin
    start_c     = (state_q == ST_IDLE) && Tx_Enable && Tx_DataAvail && !Tx_AbortFrame;
    abort_c     = ((state_q == ST_START_FLAG) || (state_q == ST_DATA)) && Tx_AbortFrame;
    flag_last_c = (bit_cnt_q == 3'd7);
    payload_c   = !abort_c && ((state_q == ST_DATA) ||
                               ((state_q == ST_START_FLAG) && flag_last_c));
    data_end_c  = payload_c && (rem_q == '0) && !rd_buff_q && !stall_c;
    room_c      = (byte_cnt_q < BCNT_W'(MAX_FRAME_BYTES));
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; state_q is the state of the bit currently on the line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start_c) state_d = ST_START_FLAG;
      ST_START_FLAG: if (abort_c) state_d = ST_ABORT;
                     else if (flag_last_c) state_d = ST_DATA;
      ST_DATA:       if (abort_c) state_d = ST_ABORT;
                     else if (data_end_c) state_d = ST_END_FLAG;
      ST_END_FLAG:   if (flag_last_c) state_d = ST_IDLE;
      ST_ABORT:      if (flag_last_c) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: computes the next line bit and its side-band strobes.
  always_comb begin
    bit_cnt_d   = bit_cnt_q + 3'd1;
    rem_d       = rem_q;
    shreg_d     = shreg_q;
    byte_cnt_d  = byte_cnt_q;
    tx_d        = 1'b1;
    rd_buff_d   = 1'b0;
    valid_d     = valid_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    overflow_d  = 1'b0;
    stuff_clr_c = 1'b0;
    stuff_adv_c = 1'b0;
    stuff_bit_c = (rem_q != '0) ? shreg_q[0] : Tx_Data[0];

    if (abort_c) begin
      bit_cnt_d   = 3'd0;
      tx_d        = ABORT_PAT[0];
      valid_d     = 1'b0;
      stuff_clr_c = 1'b1;
    end else if (payload_c) begin
      if (data_end_c) begin
        bit_cnt_d   = 3'd0;
        tx_d        = FLAG[0];
        stuff_clr_c = 1'b1;
      end else begin
        stuff_adv_c = 1'b1;
        tx_d        = line_bit_c;
        if (stall_c) begin
          // Inserted 0; a byte popped this cycle is captured now and sent after it.
          if ((rem_q == '0) && rd_buff_q) begin
            shreg_d = Tx_Data;
            rem_d   = REM_W'(8);
          end
        end else if (rem_q != '0) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          rem_d   = rem_q - REM_W'(1);
          if (rem_q == REM_W'(1) && Tx_DataAvail && room_c) begin
            rd_buff_d  = 1'b1;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end else begin
          shreg_d = {1'b0, Tx_Data[7:1]};
          rem_d   = REM_W'(7);
        end
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          byte_cnt_d = '0;
          rem_d      = '0;
          valid_d    = 1'b0;
          if (start_c) begin
            bit_cnt_d   = 3'd0;
            tx_d        = FLAG[0];
            valid_d     = 1'b1;
            stuff_clr_c = 1'b1;
          end
        end
        ST_START_FLAG: begin
          tx_d = FLAG[bit_cnt_d];
          if (bit_cnt_d == 3'd7) begin
            rd_buff_d  = 1'b1;
            byte_cnt_d = byte_cnt_q + BCNT_W'(1);
          end
        end
        ST_END_FLAG: begin
          if (flag_last_c) begin
            valid_d = 1'b0;
          end else begin
            tx_d = FLAG[bit_cnt_d];
            if (bit_cnt_d == 3'd7) begin
              done_d     = 1'b1;
              overflow_d = !room_c && Tx_DataAvail;
            end
          end
        end
        ST_ABORT: begin
          if (!flag_last_c) begin
            tx_d      = ABORT_PAT[bit_cnt_d];
            aborted_d = (bit_cnt_d == 3'd7);
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      bit_cnt_q  <= '0;
      rem_q      <= '0;
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      tx_q       <= 1'b1;
      rd_buff_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rem_q      <= rem_d;
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
      rd_buff_q  <= rd_buff_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      overflow_q <= overflow_d;
    end
  end

  assign Tx              = tx_q;
  assign Tx_RdBuff       = rd_buff_q;
  assign Tx_ValidFrame   = valid_q;
  assign Tx_Done         = done_q;
  assign Tx_AbortedTrans = aborted_q;
  assign Tx_Overflow     = overflow_q;

endmodule
